// File: rtl/banked_regfile_arb.sv
// Banked multi-port register file with per-bank write-priority and round-robin read arbitration.
// Latency: read data returned 1 cycle after grant; writes land at the granting clock edge.
// Backpressure: losing requests see ready=0 and must hold; ready depends only on valid/addr.
// Optional feature macro: BANKED_RF_WRITE_FWD_EN (same-address read is served from a same-cycle write).
module banked_regfile_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BANKS  = 8,
    parameter int RD_PORTS   = 4,
    parameter int WR_PORTS   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RD_PORTS-1:0]            rd_req_valid,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_req_addr,
    output logic [RD_PORTS-1:0]            rd_req_ready,
    output logic [RD_PORTS-1:0]            rd_rsp_valid,
    output logic [RD_PORTS*DATA_WIDTH-1:0] rd_rsp_data,
    input  logic [WR_PORTS-1:0]            wr_valid,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
    output logic [WR_PORTS-1:0]            wr_ready,
    output logic [CNT_WIDTH-1:0]           conflict_cnt
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int OFF_W     = ADDR_WIDTH - BANK_BITS;
    localparam int DEPTH     = 1 << OFF_W;
    localparam int RP_W      = (RD_PORTS > 1) ? $clog2(RD_PORTS) : 1;
    localparam int WP_W      = (WR_PORTS > 1) ? $clog2(WR_PORTS) : 1;

    // Storage: one array per bank, never reset.
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

    // Unpacked views of the flattened request buses.
    logic [ADDR_WIDTH-1:0] rd_addr_a [RD_PORTS];
    logic [BANK_BITS-1:0]  rd_bank   [RD_PORTS];
    logic [OFF_W-1:0]      rd_off    [RD_PORTS];
    logic [ADDR_WIDTH-1:0] wr_addr_a [WR_PORTS];
    logic [DATA_WIDTH-1:0] wr_dat_a  [WR_PORTS];
    logic [BANK_BITS-1:0]  wr_bank   [WR_PORTS];
    logic [OFF_W-1:0]      wr_off    [WR_PORTS];

    // Write arbitration results.
    logic [NUM_BANKS-1:0]  bank_wr_en;
    logic [WP_W-1:0]       bank_wr_sel [NUM_BANKS];
    logic [WR_PORTS-1:0]   wr_gnt;

    // Read arbitration results.
    logic [RD_PORTS-1:0]   rd_elig;
    logic [RD_PORTS-1:0]   rd_gnt;
    logic                  rd_found;
    int                    rd_win;
    int                    rd_k;

    // Registered state.
    logic [RP_W-1:0]                      rr_q [NUM_BANKS];
    logic [RP_W-1:0]                      rr_d [NUM_BANKS];
    logic [RD_PORTS-1:0]                  rd_rsp_valid_q, rd_rsp_valid_d;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rd_rsp_data_q, rd_rsp_data_d;
    logic [CNT_WIDTH-1:0]                 conflict_cnt_q, conflict_cnt_d;
    logic                                 any_stall;

    // Split flattened address/data buses into per-port bank and offset fields.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_addr_a[p] = rd_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_bank[p]   = rd_addr_a[p][BANK_BITS-1:0];
            rd_off[p]    = rd_addr_a[p][ADDR_WIDTH-1:BANK_BITS];
        end
        for (int w = 0; w < WR_PORTS; w++) begin
            wr_addr_a[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
            wr_dat_a[w]  = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            wr_bank[w]   = wr_addr_a[w][BANK_BITS-1:0];
            wr_off[w]    = wr_addr_a[w][ADDR_WIDTH-1:BANK_BITS];
        end
    end

    // Write arbitration: ascending scan so the lowest-index writer claims each bank.
    always_comb begin
        bank_wr_en = '0;
        wr_gnt     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_wr_sel[b] = '0;
        end
        if (!rst) begin
            for (int w = 0; w < WR_PORTS; w++) begin
                if (wr_valid[w] && !bank_wr_en[wr_bank[w]]) begin
                    bank_wr_en[wr_bank[w]]  = 1'b1;
                    bank_wr_sel[wr_bank[w]] = WP_W'(w);
                    wr_gnt[w]               = 1'b1;
                end
            end
        end
    end

    // Read eligibility: a bank taking a write this cycle has its single port busy,
    // unless the read targets exactly the word being written and forwarding is built in.
    always_comb begin
        rd_elig = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
`ifdef BANKED_RF_WRITE_FWD_EN
            rd_elig[p] = !rst && rd_req_valid[p] &&
                         (!bank_wr_en[rd_bank[p]] ||
                          (wr_addr_a[bank_wr_sel[rd_bank[p]]] == rd_addr_a[p]));
`else
            rd_elig[p] = !rst && rd_req_valid[p] && !bank_wr_en[rd_bank[p]];
`endif
        end
    end

    // Read arbitration: round-robin from rr per bank, then coalesce identical addresses
    // onto the winner; coalesced ports ride along without advancing the pointer.
    always_comb begin
        rd_gnt   = '0;
        rd_found = 1'b0;
        rd_win   = 0;
        rd_k     = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rr_d[b]  = rr_q[b];
            rd_found = 1'b0;
            rd_win   = 0;
            for (int i = 0; i < RD_PORTS; i++) begin
                rd_k = int'(rr_q[b]) + i;
                if (rd_k >= RD_PORTS) begin
                    rd_k = rd_k - RD_PORTS;
                end
                if (!rd_found && rd_elig[rd_k] && (rd_bank[rd_k] == BANK_BITS'(b))) begin
                    rd_found = 1'b1;
                    rd_win   = rd_k;
                end
            end
            if (rd_found) begin
                rr_d[b] = (rd_win + 1 == RD_PORTS) ? '0 : RP_W'(rd_win + 1);
                for (int p = 0; p < RD_PORTS; p++) begin
                    if (rd_elig[p] && (rd_addr_a[p] == rd_addr_a[rd_win])) begin
                        rd_gnt[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign rd_req_ready = rd_gnt;
    assign wr_ready     = wr_gnt;

    // Response capture: granted ports load the word as it stands this cycle (or the
    // forwarded write data); ungranted ports keep their last data.
    always_comb begin
        rd_rsp_valid_d = rd_gnt;
        rd_rsp_data_d  = rd_rsp_data_q;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (rd_gnt[p]) begin
`ifdef BANKED_RF_WRITE_FWD_EN
                if (bank_wr_en[rd_bank[p]]) begin
                    rd_rsp_data_d[p] = wr_dat_a[bank_wr_sel[rd_bank[p]]];
                end else begin
                    rd_rsp_data_d[p] = mem[rd_bank[p]][rd_off[p]];
                end
`else
                rd_rsp_data_d[p] = mem[rd_bank[p]][rd_off[p]];
`endif
            end
        end
    end

    // Conflict counter: one tick per cycle with any unserved request, saturating.
    always_comb begin
        any_stall      = (|(wr_valid & ~wr_gnt)) || (|(rd_req_valid & ~rd_gnt));
        conflict_cnt_d = conflict_cnt_q;
        if (any_stall && (conflict_cnt_q != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rsp_valid_q <= '0;
            rd_rsp_data_q  <= '0;
            conflict_cnt_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_q[b] <= '0;
            end
        end else begin
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
            conflict_cnt_q <= conflict_cnt_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_q[b] <= rr_d[b];
            end
        end
    end

    // Bank write port: grants are already suppressed during reset, so no reset here.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_wr_en[b]) begin
                mem[b][wr_off[bank_wr_sel[b]]] <= wr_dat_a[bank_wr_sel[b]];
            end
        end
    end

    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_data  = rd_rsp_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_banked_regfile_arb.sv
// Directed bench for banked_regfile_arb with the default 32/12/8/4/2 configuration.
// Inputs change 1 time unit after the rising edge; combinational ready is sampled on the
// falling edge and registered outputs 1 unit after the following rising edge.
module tb_banked_regfile_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_req_valid;
    logic [47:0] rd_req_addr;
    logic [3:0]  rd_req_ready;
    logic [3:0]  rd_rsp_valid;
    logic [127:0] rd_rsp_data;
    logic [1:0]  wr_valid;
    logic [23:0] wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_ready;
    logic [15:0] conflict_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_cnt;

    banked_regfile_arb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_BANKS(8),
        .RD_PORTS(4), .WR_PORTS(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        rd_req_valid = '0;
        rd_req_addr  = '0;
        wr_valid     = '0;
        wr_addr      = '0;
        wr_data      = '0;
    endtask

    task automatic set_rd(input int p, input logic [11:0] a);
        rd_req_valid[p]         = 1'b1;
        rd_req_addr[p*12 +: 12] = a;
    endtask

    task automatic set_wr(input int w, input logic [11:0] a, input logic [31:0] d);
        wr_valid[w]            = 1'b1;
        wr_addr[w*12 +: 12]    = a;
        wr_data[w*32 +: 32]    = d;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        clear_inputs();
        set_wr(0, a, d);
        tick();
        clear_inputs();
    endtask

    task automatic pulse_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        set_rd(0, 12'h001);
        set_wr(0, 12'h002, 32'h1);
        @(negedge clk);
        n_vec++;
        if (rd_req_ready !== 4'h0) begin n_err++; $display("FAIL reset_rd_ready got %h exp 0", rd_req_ready); end
        n_vec++;
        if (wr_ready !== 2'h0) begin n_err++; $display("FAIL reset_wr_ready got %h exp 0", wr_ready); end
        tick();
        n_vec++;
        if (rd_rsp_valid !== 4'h0) begin n_err++; $display("FAIL reset_rsp_valid got %h exp 0", rd_rsp_valid); end
        n_vec++;
        if (rd_rsp_data !== 128'h0) begin n_err++; $display("FAIL reset_rsp_data got %h exp 0", rd_rsp_data); end
        n_vec++;
        if (conflict_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
        clear_inputs();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_write_then_read;
        clear_inputs();
        set_wr(0, 12'h013, 32'hDEADBEEF);
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 2'b01) begin n_err++; $display("FAIL wr_then_rd_wr_ready got %b exp 01", wr_ready); end
        tick();
        clear_inputs();
        set_rd(0, 12'h013);
        @(negedge clk);
        n_vec++;
        if (rd_req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_then_rd_rd_ready got %b exp 0001", rd_req_ready); end
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_valid !== 4'b0001) begin n_err++; $display("FAIL wr_then_rd_rsp_valid got %b exp 0001", rd_rsp_valid); end
        n_vec++;
        if (rd_rsp_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_then_rd_data got %h exp deadbeef", rd_rsp_data[31:0]); end
        tick();
        n_vec++;
        if (rd_rsp_valid !== 4'b0000) begin n_err++; $display("FAIL wr_then_rd_valid_drop got %b exp 0000", rd_rsp_valid); end
    endtask

    task automatic test_parallel_banks;
        for (int i = 0; i < 4; i++) do_write(12'(i), 32'h100 + i);
        clear_inputs();
        for (int p = 0; p < 4; p++) set_rd(p, 12'(p));
        @(negedge clk);
        n_vec++;
        if (rd_req_ready !== 4'hF) begin n_err++; $display("FAIL parallel_ready got %h exp f", rd_req_ready); end
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_valid !== 4'hF) begin n_err++; $display("FAIL parallel_rsp_valid got %h exp f", rd_rsp_valid); end
        for (int p = 0; p < 4; p++) begin
            n_vec++;
            if (rd_rsp_data[p*32 +: 32] !== 32'h100 + p) begin
                n_err++; $display("FAIL parallel_data%0d got %h exp %h", p, rd_rsp_data[p*32 +: 32], 32'h100 + p);
            end
        end
        n_vec++;
        if (conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL parallel_cnt got %0d exp %0d", conflict_cnt, exp_cnt); end
    endtask

    task automatic test_bank_conflict_rr;
        pulse_reset();
        for (int i = 0; i < 4; i++) do_write(12'(i*8), 32'h300 + i);
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            for (int p = c; p < 4; p++) set_rd(p, 12'(p*8));
            @(negedge clk);
            n_vec++;
            if (rd_req_ready !== 4'(1 << c)) begin
                n_err++; $display("FAIL rr_ready_c%0d got %b exp %b", c, rd_req_ready, 4'(1 << c));
            end
            if (c < 3) exp_cnt = exp_cnt + 1'b1;
            tick();
            n_vec++;
            if (rd_rsp_valid !== 4'(1 << c)) begin
                n_err++; $display("FAIL rr_rsp_valid_c%0d got %b exp %b", c, rd_rsp_valid, 4'(1 << c));
            end
            n_vec++;
            if (rd_rsp_data[c*32 +: 32] !== 32'h300 + c) begin
                n_err++; $display("FAIL rr_data_c%0d got %h exp %h", c, rd_rsp_data[c*32 +: 32], 32'h300 + c);
            end
        end
        clear_inputs();
        n_vec++;
        if (conflict_cnt !== 16'd3) begin n_err++; $display("FAIL rr_cnt got %0d exp 3", conflict_cnt); end
    endtask

    task automatic test_coalesce;
        clear_inputs();
        set_rd(0, 12'h008);
        set_rd(1, 12'h010);
        set_rd(2, 12'h008);
        @(negedge clk);
        n_vec++;
        if (rd_req_ready !== 4'b0101) begin n_err++; $display("FAIL coalesce_ready0 got %b exp 0101", rd_req_ready); end
        exp_cnt = exp_cnt + 1'b1;
        tick();
        clear_inputs();
        set_rd(1, 12'h010);
        n_vec++;
        if (rd_rsp_valid !== 4'b0101) begin n_err++; $display("FAIL coalesce_rsp0 got %b exp 0101", rd_rsp_valid); end
        n_vec++;
        if (rd_rsp_data[31:0] !== 32'h301 || rd_rsp_data[95:64] !== 32'h301) begin
            n_err++; $display("FAIL coalesce_data got %h/%h exp 301/301", rd_rsp_data[31:0], rd_rsp_data[95:64]);
        end
        @(negedge clk);
        n_vec++;
        if (rd_req_ready !== 4'b0010) begin n_err++; $display("FAIL coalesce_ready1 got %b exp 0010", rd_req_ready); end
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_data[63:32] !== 32'h302) begin n_err++; $display("FAIL coalesce_data1 got %h exp 302", rd_rsp_data[63:32]); end
        n_vec++;
        if (conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL coalesce_cnt got %0d exp %0d", conflict_cnt, exp_cnt); end
    endtask

    task automatic test_read_write_same_bank;
        do_write(12'h00D, 32'h55);
        clear_inputs();
        set_wr(0, 12'h005, 32'h1);
`ifdef BANKED_RF_WRITE_FWD_EN
        set_rd(0, 12'h005);
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 2'b01 || rd_req_ready !== 4'b0001) begin
            n_err++; $display("FAIL fwd_ready got wr %b rd %b exp 01/0001", wr_ready, rd_req_ready);
        end
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_data[31:0] !== 32'h1) begin n_err++; $display("FAIL fwd_data got %h exp 1", rd_rsp_data[31:0]); end
`else
        set_rd(0, 12'h00D);
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 2'b01) begin n_err++; $display("FAIL rw_wr_ready got %b exp 01", wr_ready); end
        n_vec++;
        if (rd_req_ready !== 4'b0000) begin n_err++; $display("FAIL rw_rd_stall got %b exp 0000", rd_req_ready); end
        exp_cnt = exp_cnt + 1'b1;
        tick();
        clear_inputs();
        set_rd(0, 12'h00D);
        @(negedge clk);
        n_vec++;
        if (rd_req_ready !== 4'b0001) begin n_err++; $display("FAIL rw_rd_retry got %b exp 0001", rd_req_ready); end
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_data[31:0] !== 32'h55) begin n_err++; $display("FAIL rw_data got %h exp 55", rd_rsp_data[31:0]); end
`endif
        n_vec++;
        if (conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL rw_cnt got %0d exp %0d", conflict_cnt, exp_cnt); end
    endtask

    task automatic test_write_collision_and_reset;
        clear_inputs();
        set_wr(0, 12'h002, 32'hA);
        set_wr(1, 12'h002, 32'hB);
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 2'b01) begin n_err++; $display("FAIL wcol_ready0 got %b exp 01", wr_ready); end
        exp_cnt = exp_cnt + 1'b1;
        tick();
        clear_inputs();
        set_wr(1, 12'h002, 32'hB);
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 2'b10) begin n_err++; $display("FAIL wcol_ready1 got %b exp 10", wr_ready); end
        tick();
        clear_inputs();
        set_rd(3, 12'h002);
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_valid !== 4'b1000 || rd_rsp_data[127:96] !== 32'hB) begin
            n_err++; $display("FAIL wcol_last_wins got v %b d %h exp 1000/b", rd_rsp_valid, rd_rsp_data[127:96]);
        end
        n_vec++;
        if (conflict_cnt !== exp_cnt) begin n_err++; $display("FAIL wcol_cnt got %0d exp %0d", conflict_cnt, exp_cnt); end
        // Reset lands in the middle of a fresh collision plus a blocked read.
        set_wr(0, 12'h002, 32'hC);
        set_wr(1, 12'h002, 32'hD);
        set_rd(0, 12'h00A);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (wr_ready !== 2'b00 || rd_req_ready !== 4'b0000) begin
            n_err++; $display("FAIL rst_stall_ready got wr %b rd %b exp 00/0000", wr_ready, rd_req_ready);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        n_vec++;
        if (rd_rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_stall_rsp got %b exp 0000", rd_rsp_valid); end
        n_vec++;
        if (conflict_cnt !== 16'h0) begin n_err++; $display("FAIL rst_stall_cnt got %0d exp 0", conflict_cnt); end
        set_rd(0, 12'h002);
        tick();
        clear_inputs();
        n_vec++;
        if (rd_rsp_valid[0] !== 1'b1 || rd_rsp_data[31:0] !== 32'hB) begin
            n_err++; $display("FAIL rst_no_write got v %b d %h exp 1/b", rd_rsp_valid[0], rd_rsp_data[31:0]);
        end
    endtask

    initial begin
        exp_cnt = '0;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_write_then_read();
        test_parallel_banks();
        test_bank_conflict_rr();
        test_coalesce();
        test_read_write_same_bank();
        test_write_collision_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
